// File: rtl/dma_chan_arbiter.sv
// rtl/dma_chan_arbiter.sv - N-channel DMA request arbiter with HRQ/HLDA bus handshake
//
// Purpose: synchronises DREQ, applies mask / software requests / polarity, requests
// the bus with HRQ, and on HLDA grants one channel (fixed or rotating priority)
// until timing control reports end of service or the CPU withdraws HLDA.
//
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   DREQ[NUM_CH]     asynchronous channel requests (active low when DREQ_SENSE_LOW)
//   HLDA             CPU hold acknowledge
//   MASK[NUM_CH]     1 = ignore that channel's hardware DREQ
//   SW_REQ[NUM_CH]   software request bits (not masked)
//   ROT_PRI          1 = rotating priority, 0 = fixed (ch0 highest)
//   DREQ_SENSE_LOW   DREQ polarity select
//   DACK_SENSE_HIGH  DACK polarity select
//   XFER_DONE        end-of-service pulse for the granted channel
//   HRQ              hold request to CPU
//   DACK[NUM_CH]     one-hot acknowledge
//   CH_ID[CHW]       granted channel index
//   BUSY             a channel is granted
//   SW_REQ_CLR       pulse clearing the served channel's software request
//   ABORT            pulse: grant lost because HLDA dropped
module dma_chan_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CHW         = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] MASK,
  input  logic [NUM_CH-1:0] SW_REQ,
  input  logic              ROT_PRI,
  input  logic              DREQ_SENSE_LOW,
  input  logic              DACK_SENSE_HIGH,
  input  logic              XFER_DONE,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CHW-1:0]    CH_ID,
  output logic              BUSY,
  output logic [NUM_CH-1:0] SW_REQ_CLR,
  output logic              ABORT
);

  localparam logic [1:0] ST_SI = 2'd0;
  localparam logic [1:0] ST_S0 = 2'd1;
  localparam logic [1:0] ST_SA = 2'd2;

  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);
  localparam logic [CHW:0]   NUM_CH_W = (CHW + 1)'(NUM_CH);

  logic [1:0]        state_q;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant_q;
  logic [CHW-1:0]    ch_id_q;
  logic [CHW-1:0]    ptr_q;
  logic [NUM_CH-1:0] clr_q;
  logic              abort_q;

  logic [CHW-1:0]    start;
  logic [CHW:0]      cand;
  logic              win_found;
  logic [CHW-1:0]    win_id;
  logic [NUM_CH-1:0] win_oh;

  // Raw DREQ is synchronised; polarity is applied after the chain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= DREQ;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign req = ((sync_q[SYNC_STAGES-1] ^ {NUM_CH{DREQ_SENSE_LOW}}) & ~MASK) | SW_REQ;

  // Circular search starting at the priority pointer (0 in fixed mode).
  assign start = ROT_PRI ? ptr_q : '0;

  always_comb begin
    cand      = '0;
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = {1'b0, start} + (CHW + 1)'(off);
      if (cand >= NUM_CH_W) cand = cand - NUM_CH_W;
      if (!win_found && req[cand[CHW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[CHW-1:0];
      end
    end
    win_oh[win_id] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_SI;
      grant_q <= '0;
      ch_id_q <= '0;
      ptr_q   <= '0;
      clr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      clr_q   <= '0;
      abort_q <= 1'b0;
      if (!ROT_PRI) ptr_q <= '0;
      case (state_q)
        ST_SI: begin
          // A still-high HLDA belongs to the previous grant; wait for it to drop.
          if (|req && !HLDA) state_q <= ST_S0;
        end
        ST_S0: begin
          if (!(|req)) begin
            state_q <= ST_SI;
          end else if (HLDA) begin
            state_q <= ST_SA;
            grant_q <= win_oh;
            ch_id_q <= win_id;
          end
        end
        ST_SA: begin
          // Completion takes precedence over a simultaneous HLDA drop.
          if (XFER_DONE) begin
            state_q <= ST_SI;
            grant_q <= '0;
            clr_q   <= grant_q & SW_REQ;
            if (ROT_PRI) ptr_q <= (ch_id_q == LAST_CH) ? '0 : ch_id_q + CHW'(1);
          end else if (!HLDA) begin
            state_q <= ST_SI;
            grant_q <= '0;
            abort_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_SI;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign HRQ        = (state_q != ST_SI);
  assign BUSY       = (state_q == ST_SA);
  assign DACK       = DACK_SENSE_HIGH ? grant_q : ~grant_q;
  assign CH_ID      = ch_id_q;
  assign SW_REQ_CLR = clr_q;
  assign ABORT      = abort_q;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// tb/tb_dma_chan_arbiter.sv - directed self-checking bench for dma_chan_arbiter
module tb_dma_chan_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] MASK;
  logic [3:0] SW_REQ;
  logic       ROT_PRI;
  logic       DREQ_SENSE_LOW;
  logic       DACK_SENSE_HIGH;
  logic       XFER_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] CH_ID;
  logic       BUSY;
  logic [3:0] SW_REQ_CLR;
  logic       ABORT;

  int checks = 0;
  int errors = 0;

  dma_chan_arbiter #(.NUM_CH(4), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .MASK(MASK), .SW_REQ(SW_REQ),
    .ROT_PRI(ROT_PRI), .DREQ_SENSE_LOW(DREQ_SENSE_LOW), .DACK_SENSE_HIGH(DACK_SENSE_HIGH),
    .XFER_DONE(XFER_DONE), .HRQ(HRQ), .DACK(DACK), .CH_ID(CH_ID), .BUSY(BUSY),
    .SW_REQ_CLR(SW_REQ_CLR), .ABORT(ABORT)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One full service from SI/S0 with requests already synchronised.
  task automatic serve(output logic [3:0] seen);
    HLDA = 1'b0;
    tick(1);
    HLDA = 1'b1;
    tick(1);
    seen = DACK;
    XFER_DONE = 1'b1;
    tick(1);
    XFER_DONE = 1'b0;
  endtask

  task automatic cleanup;
    DREQ = '0; SW_REQ = '0; MASK = '0;
    tick(3);
    HLDA = 1'b0; ROT_PRI = 1'b0;
    tick(2);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick(10);
    checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL reset_hrq: got %b exp 0", HRQ); end
    checks++; if (DACK !== 4'b0000) begin errors++; $display("FAIL reset_dack: got %b exp 0000", DACK); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", BUSY); end
    checks++; if (CH_ID !== 2'd0) begin errors++; $display("FAIL reset_chid: got %0d exp 0", CH_ID); end
    checks++; if (SW_REQ_CLR !== 4'b0000 || ABORT !== 1'b0) begin errors++; $display("FAIL reset_pulses: got clr=%b abort=%b exp 0000/0", SW_REQ_CLR, ABORT); end
    DACK_SENSE_HIGH = 1'b0;
    #1;
    checks++; if (DACK !== 4'b1111) begin errors++; $display("FAIL reset_dack_low: got %b exp 1111", DACK); end
    DACK_SENSE_HIGH = 1'b1;
    RESET = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_grant;
    DREQ = 4'b0100;
    tick(2);
    checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL basic_hrq_early: got %b exp 0", HRQ); end
    tick(1);
    checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL basic_hrq_latency: got %b exp 1", HRQ); end
    HLDA = 1'b1;
    tick(1);
    checks++; if (DACK !== 4'b0100 || CH_ID !== 2'd2 || BUSY !== 1'b1) begin errors++; $display("FAIL basic_grant: got dack=%b id=%0d busy=%b exp 0100/2/1", DACK, CH_ID, BUSY); end
    XFER_DONE = 1'b1;
    tick(1);
    XFER_DONE = 1'b0;
    checks++; if (HRQ !== 1'b0 || DACK !== 4'b0000 || BUSY !== 1'b0) begin errors++; $display("FAIL basic_done: got hrq=%b dack=%b busy=%b exp 0/0000/0", HRQ, DACK, BUSY); end
    checks++; if (SW_REQ_CLR !== 4'b0000) begin errors++; $display("FAIL basic_swclr: got %b exp 0000", SW_REQ_CLR); end
    cleanup();
  endtask

  task automatic test_priority;
    logic [3:0] seen;
    logic [3:0] exp_rot [3];
    logic [3:0] exp_wrap [5];
    exp_rot  = '{4'b0010, 4'b1000, 4'b0010};
    exp_wrap = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    DREQ = 4'b1010;
    tick(3);
    serve(seen);
    checks++; if (seen !== 4'b0010) begin errors++; $display("FAIL fixed_pri: got %b exp 0010", seen); end
    ROT_PRI = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serve(seen);
      checks++; if (seen !== exp_rot[i]) begin errors++; $display("FAIL rot_1010_%0d: got %b exp %b", i, seen, exp_rot[i]); end
    end
    ROT_PRI = 1'b0;
    DREQ = 4'b1111;
    tick(3);
    ROT_PRI = 1'b1;
    for (int i = 0; i < 5; i++) begin
      serve(seen);
      checks++; if (seen !== exp_wrap[i]) begin errors++; $display("FAIL rot_wrap_%0d: got %b exp %b", i, seen, exp_wrap[i]); end
    end
    cleanup();
  endtask

  task automatic test_mask_swreq;
    MASK = 4'b0001;
    DREQ = 4'b0001;
    tick(4);
    checks++; if (HRQ !== 1'b0) begin errors++; $display("FAIL mask_hrq: got %b exp 0", HRQ); end
    SW_REQ = 4'b0001;
    tick(1);
    checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL swreq_hrq: got %b exp 1", HRQ); end
    HLDA = 1'b1;
    tick(1);
    checks++; if (DACK !== 4'b0001) begin errors++; $display("FAIL swreq_grant: got %b exp 0001", DACK); end
    XFER_DONE = 1'b1;
    tick(1);
    XFER_DONE = 1'b0;
    checks++; if (SW_REQ_CLR !== 4'b0001) begin errors++; $display("FAIL swreq_clr: got %b exp 0001", SW_REQ_CLR); end
    SW_REQ = '0;
    tick(1);
    checks++; if (SW_REQ_CLR !== 4'b0000) begin errors++; $display("FAIL swreq_clr_pulse: got %b exp 0000", SW_REQ_CLR); end
    cleanup();
  endtask

  task automatic test_abort;
    ROT_PRI = 1'b1;
    DREQ = 4'b1100;
    tick(3);
    HLDA = 1'b1;
    tick(1);
    checks++; if (DACK !== 4'b0100) begin errors++; $display("FAIL abort_pre_grant: got %b exp 0100", DACK); end
    HLDA = 1'b0;
    tick(1);
    checks++; if (DACK !== 4'b0000 || HRQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL abort_drop: got dack=%b hrq=%b busy=%b exp 0000/0/0", DACK, HRQ, BUSY); end
    checks++; if (ABORT !== 1'b1 || SW_REQ_CLR !== 4'b0000) begin errors++; $display("FAIL abort_pulse: got abort=%b clr=%b exp 1/0000", ABORT, SW_REQ_CLR); end
    tick(1);
    checks++; if (ABORT !== 1'b0) begin errors++; $display("FAIL abort_width: got %b exp 0", ABORT); end
    HLDA = 1'b1;
    tick(1);
    checks++; if (DACK !== 4'b0100) begin errors++; $display("FAIL abort_regrant: got %b exp 0100", DACK); end
    // Completion and HLDA drop together: normal completion.
    XFER_DONE = 1'b1;
    HLDA = 1'b0;
    tick(1);
    XFER_DONE = 1'b0;
    checks++; if (ABORT !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL done_vs_hlda: got abort=%b busy=%b exp 0/0", ABORT, BUSY); end
    cleanup();
    DREQ = 4'b0001;
    tick(3);
    checks++; if (HRQ !== 1'b1) begin errors++; $display("FAIL retract_hrq_up: got %b exp 1", HRQ); end
    DREQ = 4'b0000;
    tick(3);
    checks++; if (HRQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL retract_hrq_down: got hrq=%b busy=%b exp 0/0", HRQ, BUSY); end
    cleanup();
  endtask

  task automatic test_polarity_reset;
    DREQ_SENSE_LOW = 1'b1;
    DREQ = 4'b1110;
    tick(3);
    HLDA = 1'b1;
    tick(1);
    checks++; if (DACK !== 4'b0001 || CH_ID !== 2'd0) begin errors++; $display("FAIL sense_low_grant: got dack=%b id=%0d exp 0001/0", DACK, CH_ID); end
    DACK_SENSE_HIGH = 1'b0;
    #1;
    checks++; if (DACK !== 4'b1110) begin errors++; $display("FAIL dack_sense_flip: got %b exp 1110", DACK); end
    DACK_SENSE_HIGH = 1'b1;
    #1;
    RESET = 1'b1;
    #1;
    checks++; if (DACK !== 4'b0000 || BUSY !== 1'b0 || HRQ !== 1'b0) begin errors++; $display("FAIL async_reset: got dack=%b busy=%b hrq=%b exp 0000/0/0", DACK, BUSY, HRQ); end
    tick(2);
    RESET = 1'b0;
    tick(1);
    checks++; if (ABORT !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_no_abort: got abort=%b busy=%b exp 0/0", ABORT, BUSY); end
    DREQ_SENSE_LOW = 1'b0;
    cleanup();
  endtask

  initial begin
    RESET = 1'b1; DREQ = '0; HLDA = 1'b0; MASK = '0; SW_REQ = '0; ROT_PRI = 1'b0;
    DREQ_SENSE_LOW = 1'b0; DACK_SENSE_HIGH = 1'b1; XFER_DONE = 1'b0;
    test_reset();
    test_basic_grant();
    test_priority();
    test_mask_swreq();
    test_abort();
    test_polarity_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
